// File: rtl/dmem_arbiter.sv
// Two-port arbiter and single-access sequencer in front of the single-port dmem.
// One request in flight: handshake -> ACCESS (dmem driven) -> RESP (response pulse).
module dmem_arbiter #(
  parameter int XLEN        = 32,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            p0_req,
  input  logic            p0_we,
  input  logic [XLEN-1:0] p0_addr,
  input  logic [XLEN-1:0] p0_wdata,
  input  logic [1:0]      p0_size,
  input  logic            p0_lu,
  output logic            p0_gnt,
  output logic            p0_rvalid,
  output logic [XLEN-1:0] p0_rdata,
  output logic            p0_err,
  input  logic            p1_req,
  input  logic            p1_we,
  input  logic [XLEN-1:0] p1_addr,
  input  logic [XLEN-1:0] p1_wdata,
  input  logic [1:0]      p1_size,
  input  logic            p1_lu,
  output logic            p1_gnt,
  output logic            p1_rvalid,
  output logic [XLEN-1:0] p1_rdata,
  output logic            p1_err,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_a,
  output logic [XLEN-1:0] mem_wd,
  output logic            mem_lb,
  output logic            mem_lh,
  output logic            mem_sb,
  output logic            mem_sh,
  output logic            mem_lu,
  input  logic [XLEN-1:0] mem_rd
);

  localparam int NPORT = 2;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [1:0]      size;
    logic            lu;
  } req_t;

  function automatic logic bad_req(req_t r);
    return (r.size == 2'b00) ||
           (r.size == 2'b11 && r.addr[1:0] != 2'b00) ||
           (r.size == 2'b10 && r.addr[0]);
  endfunction

  state_e                      state_q, state_d;
  logic                        rr_last_q, rr_last_d;
  logic                        owner_q, owner_d;
  req_t                        rq_q, rq_d;
  logic                        err_q, err_d;
  logic [XLEN-1:0]             rdata_q, rdata_d;

  req_t [NPORT-1:0]            req_in;
  logic [NPORT-1:0]            req_v;
  logic [NPORT-1:0]            gnt;
  logic [NPORT-1:0]            rvalid;
  logic [NPORT-1:0][XLEN-1:0]  rdata;
  logic [NPORT-1:0]            err;
  logic                        can_gnt;
  logic                        hs;
  logic                        sel;

  assign req_in[0] = {p0_we, p0_addr, p0_wdata, p0_size, p0_lu};
  assign req_in[1] = {p1_we, p1_addr, p1_wdata, p1_size, p1_lu};
  assign req_v     = {p1_req, p0_req};

  // Grants are only offered when the sequencer can take a new access next edge.
  assign can_gnt = !reset && (state_q == IDLE || state_q == RESP);

  always_comb begin
    gnt = '0;
    if (can_gnt) begin
      case (req_v)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (ROUND_ROBIN && !rr_last_q) ? 2'b10 : 2'b01;
        default: gnt = '0;
      endcase
    end
  end

  assign hs  = |(gnt & req_v);
  assign sel = gnt[1];

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    owner_d   = owner_q;
    rq_d      = rq_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    case (state_q)
      ACCESS: begin
        rdata_d = (!rq_q.we && !err_q) ? mem_rd : '0;
        state_d = RESP;
      end
      IDLE, RESP: begin
        if (hs) begin
          owner_d   = sel;
          rq_d      = req_in[sel];
          err_d     = bad_req(req_in[sel]);
          rr_last_d = sel;
          state_d   = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
      owner_q   <= 1'b0;
      rq_q      <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      owner_q   <= owner_d;
      rq_q      <= rq_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  // dmem strobes decode straight from the state flop, so an async reset kills them at once.
  always_comb begin
    mem_we = 1'b0;
    mem_a  = '0;
    mem_wd = '0;
    mem_lb = 1'b0;
    mem_lh = 1'b0;
    mem_sb = 1'b0;
    mem_sh = 1'b0;
    mem_lu = 1'b0;
    if (state_q == ACCESS && !err_q) begin
      mem_a  = rq_q.addr;
      mem_wd = rq_q.wdata;
      mem_lu = rq_q.lu;
      if (rq_q.we) begin
        mem_we = 1'b1;
        mem_sb = rq_q.size[1];
        mem_sh = rq_q.size[0];
      end else begin
        mem_lb = rq_q.size[1];
        mem_lh = rq_q.size[0];
      end
    end
  end

  for (genvar i = 0; i < NPORT; i++) begin : g_resp
    assign rvalid[i] = (state_q == RESP) && (owner_q == 1'(i));
    assign rdata[i]  = rvalid[i] ? rdata_q : '0;
    assign err[i]    = rvalid[i] & err_q;
  end

  assign p0_gnt    = gnt[0];
  assign p1_gnt    = gnt[1];
  assign p0_rvalid = rvalid[0];
  assign p1_rvalid = rvalid[1];
  assign p0_rdata  = rdata[0];
  assign p1_rdata  = rdata[1];
  assign p0_err    = err[0];
  assign p1_err    = err[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: dmem model, response scoreboard, round-robin and
// fixed-priority instances.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // round-robin instance
  logic        p0_req, p0_we, p0_lu, p1_req, p1_we, p1_lu;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [1:0]  p0_size, p1_size;
  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_we, mem_lb, mem_lh, mem_sb, mem_sh, mem_lu;
  logic [31:0] mem_a, mem_wd, mem_rd;

  // fixed-priority instance
  logic        f_req0, f_req1, f_gnt0, f_gnt1, f_rv0, f_rv1, f_err0, f_err1;
  logic [31:0] f_rd0, f_rd1, f_a, f_wd;
  logic        f_we, f_lb, f_lh, f_sb, f_sh, f_lu;

  dmem_arbiter #(.XLEN(32), .ROUND_ROBIN(1'b1)) dut (
    .clk(clk), .reset(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_size(p0_size), .p0_lu(p0_lu), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
    .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_size(p1_size), .p1_lu(p1_lu), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_lb(mem_lb), .mem_lh(mem_lh),
    .mem_sb(mem_sb), .mem_sh(mem_sh), .mem_lu(mem_lu), .mem_rd(mem_rd)
  );

  dmem_arbiter #(.XLEN(32), .ROUND_ROBIN(1'b0)) dut_fp (
    .clk(clk), .reset(rst),
    .p0_req(f_req0), .p0_we(1'b0), .p0_addr(32'h0), .p0_wdata(32'h0),
    .p0_size(2'b11), .p0_lu(1'b0), .p0_gnt(f_gnt0), .p0_rvalid(f_rv0),
    .p0_rdata(f_rd0), .p0_err(f_err0),
    .p1_req(f_req1), .p1_we(1'b0), .p1_addr(32'h4), .p1_wdata(32'h0),
    .p1_size(2'b11), .p1_lu(1'b0), .p1_gnt(f_gnt1), .p1_rvalid(f_rv1),
    .p1_rdata(f_rd1), .p1_err(f_err1),
    .mem_we(f_we), .mem_a(f_a), .mem_wd(f_wd), .mem_lb(f_lb), .mem_lh(f_lh),
    .mem_sb(f_sb), .mem_sh(f_sh), .mem_lu(f_lu), .mem_rd(32'h0)
  );

  // little-endian dmem model with sub-word extension on read
  logic [31:0] mem [0:15];
  always @(posedge clk) begin
    if (mem_we) begin
      case ({mem_sb, mem_sh})
        2'b11: mem[mem_a[5:2]] <= mem_wd;
        2'b10: if (mem_a[1]) mem[mem_a[5:2]][31:16] <= mem_wd[15:0];
               else          mem[mem_a[5:2]][15:0]  <= mem_wd[15:0];
        2'b01: mem[mem_a[5:2]][8*mem_a[1:0] +: 8] <= mem_wd[7:0];
        default: ;
      endcase
    end
  end

  logic [31:0] mw;
  logic [15:0] mh;
  logic [7:0]  mb;
  always_comb begin
    mw     = mem[mem_a[5:2]];
    mh     = mem_a[1] ? mw[31:16] : mw[15:0];
    mb     = mw[8*mem_a[1:0] +: 8];
    mem_rd = 32'h0;
    case ({mem_lb, mem_lh})
      2'b11: mem_rd = mw;
      2'b10: mem_rd = mem_lu ? {16'h0, mh} : {{16{mh[15]}}, mh};
      2'b01: mem_rd = mem_lu ? {24'h0, mb} : {{24{mb[7]}}, mb};
      default: mem_rd = 32'h0;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int       checks = 0;
  int       errs   = 0;
  int       we_cnt = 0;
  logic [1:0] last_ss = 2'b00;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and check whatever the DUT presents there.
  task automatic step();
    exp_t e;
    logic [1:0]  rv;
    logic [31:0] rd [2];
    logic [1:0]  er;
    @(negedge clk);
    if (mem_we) begin
      we_cnt++;
      last_ss = {mem_sb, mem_sh};
    end
    rv = {p1_rvalid, p0_rvalid};
    rd[0] = p0_rdata; rd[1] = p1_rdata;
    er = {p1_err, p0_err};
    chk("rv_onehot", {31'h0, rv[0] & rv[1]}, 32'h0);
    for (int p = 0; p < 2; p++) begin
      if (rv[p]) begin
        if (sb.size() == 0) chk("sb_pending", sb.size(), 1);
        else begin
          e = sb.pop_front();
          chk("rv_owner", p, e.port);
          chk("rdata", rd[p], e.rdata);
          chk("err", {31'h0, er[p]}, {31'h0, e.err});
          chk("latency", cyc, e.cyc);
        end
      end
    end
  endtask

  task automatic drive(int p, logic r, logic we, logic [31:0] a, logic [31:0] wd,
                       logic [1:0] sz, logic lu);
    if (p == 0) begin
      p0_req = r; p0_we = we; p0_addr = a; p0_wdata = wd; p0_size = sz; p0_lu = lu;
    end else begin
      p1_req = r; p1_we = we; p1_addr = a; p1_wdata = wd; p1_size = sz; p1_lu = lu;
    end
  endtask

  task automatic issue(int p, logic we, logic [31:0] a, logic [31:0] wd, logic [1:0] sz,
                       logic lu, logic [31:0] erd, logic eerr);
    logic g;
    bit   done;
    done = 0;
    g    = 1'b0;
    drive(p, 1'b1, we, a, wd, sz, lu);
    #1;
    for (int i = 0; i < 20 && !done; i++) begin
      g = (p == 0) ? p0_gnt : p1_gnt;
      if (g) begin
        sb.push_back('{port: p, rdata: erd, err: eerr, cyc: cyc + 2});
        done = 1;
      end
      step();
    end
    if (!done) chk("gnt_timeout", {31'h0, g}, 32'h1);
    if (p == 0) p0_req = 1'b0; else p1_req = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() != 0; i++) step();
    chk("resp_timeout", sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, n, gp, last, cnt;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    f_req0 = 1'b0; f_req1 = 1'b0;
    rst = 1'b1;
    step(); step();
    // reset state
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_ctl", {26'h0, mem_lb, mem_lh, mem_sb, mem_sh, mem_lu, p0_gnt}, 32'h0);
    chk("rst_rvalid", {30'h0, p1_rvalid, p0_rvalid}, 32'h0);
    chk("rst_rdata", p0_rdata, 32'h0);
    chk("rst_err", {30'h0, p1_err, p0_err}, 32'h0);
    rst = 1'b0;
    step();

    // word store then load
    w0 = we_cnt;
    issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b11, 1'b0, 32'h0, 1'b0);
    drain();
    chk("store_we_once", we_cnt - w0, 1);
    chk("store_sbsh", {30'h0, last_ss}, 32'h3);
    issue(0, 1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 32'hDEADBEEF, 1'b0);
    drain();

    // sub-word loads
    issue(0, 1'b0, 32'h13, 32'h0, 2'b01, 1'b0, 32'hFFFFFFDE, 1'b0);
    drain();
    issue(0, 1'b0, 32'h13, 32'h0, 2'b01, 1'b1, 32'h000000DE, 1'b0);
    drain();
    issue(0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hFFFFBEEF, 1'b0);
    drain();

    // misaligned / invalid accesses
    w0 = we_cnt;
    issue(0, 1'b1, 32'h12, 32'h11111111, 2'b11, 1'b0, 32'h0, 1'b1);
    drain();
    chk("misalign_no_we", we_cnt - w0, 0);
    issue(0, 1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 32'hDEADBEEF, 1'b0);
    drain();
    issue(0, 1'b0, 32'h10, 32'h0, 2'b00, 1'b0, 32'h0, 1'b1);
    drain();
    issue(1, 1'b0, 32'h11, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1);
    drain();

    // half store into upper half, port 1
    w0 = we_cnt;
    issue(1, 1'b1, 32'h12, 32'h0000CAFE, 2'b10, 1'b0, 32'h0, 1'b0);
    drain();
    chk("half_we_once", we_cnt - w0, 1);
    chk("half_sbsh", {30'h0, last_ss}, 32'h2);
    issue(0, 1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 32'hCAFEBEEF, 1'b0);
    drain();

    // reset during a store's ACCESS cycle
    drive(0, 1'b1, 1'b1, 32'h20, 32'h12345678, 2'b11, 1'b0);
    #1;
    chk("rst_test_gnt", {31'h0, p0_gnt}, 32'h1);
    step();
    p0_req = 1'b0;
    chk("we_in_access", {31'h0, mem_we}, 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("we_async_drop", {31'h0, mem_we}, 32'h0);
    step();
    rst = 1'b0;
    w0 = we_cnt;
    step(); step(); step();
    chk("rst_no_we", we_cnt - w0, 0);
    chk("rst_no_resp", sb.size(), 0);

    // contention, round robin: 0,1,0,1 back-to-back
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 2'b11, 1'b0);
    drive(1, 1'b1, 1'b0, 32'h10, 32'h0, 2'b11, 1'b0);
    #1;
    n = 0; last = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      if (p0_gnt || p1_gnt) begin
        gp = p1_gnt ? 1 : 0;
        chk("rr_order", gp, n % 2);
        chk("gnt_onehot", {31'h0, p0_gnt & p1_gnt}, 32'h0);
        if (n > 0) chk("b2b_spacing", cyc - last, 2);
        last = cyc;
        sb.push_back('{port: gp, rdata: 32'hCAFEBEEF, err: 1'b0, cyc: cyc + 2});
        n++;
      end
      step();
    end
    p0_req = 1'b0; p1_req = 1'b0;
    chk("rr_count", n, 4);
    drain();

    // fixed priority: port 1 starved until port 0 drops
    f_req0 = 1'b1; f_req1 = 1'b1;
    #1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      chk("fp_no_p1", {31'h0, f_gnt1}, 32'h0);
      chk("fp_no_store", {31'h0, f_we}, 32'h0);
      if (f_gnt0) cnt++;
      step();
    end
    chk("fp_p0_grants", cnt, 6);
    for (int i = 0; i < 4 && !f_gnt0; i++) step();
    chk("fp_p0_gnt", {31'h0, f_gnt0}, 32'h1);
    step();
    f_req0 = 1'b0;
    #1;
    chk("fp_access_no_gnt", {31'h0, f_gnt1}, 32'h0);
    step();
    chk("fp_p1_after_drop", {31'h0, f_gnt1}, 32'h1);
    step();
    f_req1 = 1'b0;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

endmodule
